// File: rtl/audio_pkg.sv
// Shared stereo sample types for the I2S receiver consumers and downstream DSP stages.
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] left;
    logic signed [SAMPLE_W-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port stereo sample store: synchronous write, synchronous read-old-data.
// One-cycle read latency, no reset on storage or read register so it maps onto block/distributed RAM.
module sample_ram
  import audio_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  stereo_sample_t    wr_dat,
  input  logic [ADDR_W-1:0] rd_addr,
  output stereo_sample_t    rd_dat
);

  stereo_sample_t mem_q [DEPTH];
  stereo_sample_t rd_dat_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
    rd_dat_q <= mem_q[rd_addr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/stereo_sample_fifo.sv
// Show-ahead stereo sample FIFO between the fixed-rate I2S receiver and valid/ready consumers.
// Write-to-valid latency 1 cycle; when full without a pop, new samples are dropped and counted.
module stereo_sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = $clog2(DEPTH) + 1,
  parameter int DROP_W  = 16
) (
  input  logic                       clock_in,
  input  logic                       reset_in,
  input  logic signed [SAMPLE_W-1:0] left_sample_in,
  input  logic signed [SAMPLE_W-1:0] right_sample_in,
  input  logic                       new_sample_in,
  output logic signed [SAMPLE_W-1:0] left_sample_out,
  output logic signed [SAMPLE_W-1:0] right_sample_out,
  output logic                       sample_valid_out,
  input  logic                       sample_ready_in,
  output logic [LEVEL_W-1:0]         fill_level_out,
  output logic                       overflow_out,
  output logic [DROP_W-1:0]          drop_count_out
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic               valid_q, valid_d;
  logic               byp_sel_q, byp_sel_d;
  logic               overflow_q, overflow_d;
  stereo_sample_t     byp_q, byp_d;
  stereo_sample_t     wr_dat, rd_dat, head;
  logic               full, push, pop, drop;

  assign wr_dat = {left_sample_in, right_sample_in};

  always_comb begin
    full       = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    pop        = valid_q && sample_ready_in;
    push       = new_sample_in && (!full || pop);
    drop       = new_sample_in && full && !pop;

    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    level_d    = level_q + LEVEL_W'(push) - LEVEL_W'(pop);
    valid_d    = (level_d != '0);

    // The sync RAM read issued this edge returns pre-write data, so an entry
    // that becomes the head as it is written is served from the bypass register.
    byp_sel_d  = push && (level_q == LEVEL_W'(pop));
    byp_d      = byp_sel_d ? wr_dat : byp_q;

    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != {DROP_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      valid_q    <= 1'b0;
      byp_sel_q  <= 1'b0;
      byp_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      valid_q    <= valid_d;
      byp_sel_q  <= byp_sel_d;
      byp_q      <= byp_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Reading at the next head address keeps the RAM output aligned with rd_ptr_q.
  sample_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clock_in),
    .wr_en   (push),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_dat  (wr_dat),
    .rd_addr (rd_ptr_d[ADDR_W-1:0]),
    .rd_dat  (rd_dat)
  );

  assign head             = byp_sel_q ? byp_q : rd_dat;
  assign left_sample_out  = valid_q ? head.left  : '0;
  assign right_sample_out = valid_q ? head.right : '0;
  assign sample_valid_out = valid_q;
  assign fill_level_out   = level_q;
  assign overflow_out     = overflow_q;
  assign drop_count_out   = drop_cnt_q;

endmodule

// File: tb/tb_stereo_sample_fifo.sv
// Self-checking bench for stereo_sample_fifo against a queue-based reference model.
module tb_stereo_sample_fifo;

  localparam int DEPTH   = 16;
  localparam int LEVEL_W = 5;
  localparam int DROP_W  = 16;
  localparam int V_W     = 1 + LEVEL_W + 1 + DROP_W + 32;

  logic               clock_in = 1'b0;
  logic               reset_in = 1'b0;
  logic [15:0]        left_sample_in = '0;
  logic [15:0]        right_sample_in = '0;
  logic               new_sample_in = 1'b0;
  logic [15:0]        left_sample_out;
  logic [15:0]        right_sample_out;
  logic               sample_valid_out;
  logic               sample_ready_in = 1'b0;
  logic [LEVEL_W-1:0] fill_level_out;
  logic               overflow_out;
  logic [DROP_W-1:0]  drop_count_out;

  int tests = 0;
  int fails = 0;

  logic [31:0] mq[$];
  int          m_drops = 0;
  bit          m_ovf = 1'b0;

  stereo_sample_fifo #(
    .DEPTH   (DEPTH),
    .LEVEL_W (LEVEL_W),
    .DROP_W  (DROP_W)
  ) dut (
    .clock_in         (clock_in),
    .reset_in         (reset_in),
    .left_sample_in   (left_sample_in),
    .right_sample_in  (right_sample_in),
    .new_sample_in    (new_sample_in),
    .left_sample_out  (left_sample_out),
    .right_sample_out (right_sample_out),
    .sample_valid_out (sample_valid_out),
    .sample_ready_in  (sample_ready_in),
    .fill_level_out   (fill_level_out),
    .overflow_out     (overflow_out),
    .drop_count_out   (drop_count_out)
  );

  always #5 clock_in = ~clock_in;

  function automatic logic [V_W-1:0] exp_vec();
    logic [31:0] d;
    d = (mq.size() != 0) ? mq[0] : 32'h0;
    return {(mq.size() != 0), LEVEL_W'(mq.size()), m_ovf, DROP_W'(m_drops), d};
  endfunction

  function automatic logic [V_W-1:0] obs_vec();
    logic [31:0] d;
    d = sample_valid_out ? {left_sample_out, right_sample_out} : 32'h0;
    return {sample_valid_out, fill_level_out, overflow_out, drop_count_out, d};
  endfunction

  // One clock: apply inputs, advance the model by the FIFO rules, sample 1 unit after the edge.
  task automatic step(input bit nw, input logic [15:0] l, input logic [15:0] r, input bit rdy);
    bit pop;
    bit full;
    new_sample_in   = nw;
    left_sample_in  = l;
    right_sample_in = r;
    sample_ready_in = rdy;
    pop  = (mq.size() != 0) && rdy;
    full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (nw) begin
      if (!full || pop) mq.push_back({l, r});
      else begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
    end
    @(posedge clock_in);
    #1;
  endtask

  task automatic do_reset();
    new_sample_in   = 1'b0;
    sample_ready_in = 1'b0;
    reset_in        = 1'b1;
    mq.delete();
    m_drops = 0;
    m_ovf   = 1'b0;
    repeat (2) @(posedge clock_in);
    #1;
    reset_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({sample_valid_out, fill_level_out, overflow_out, drop_count_out, left_sample_out, right_sample_out} !== '0) begin
      fails++;
      $display("FAIL reset_state: got v=%b lvl=%0d ovf=%b drops=%0d L=%h R=%h, want all zero",
               sample_valid_out, fill_level_out, overflow_out, drop_count_out, left_sample_out, right_sample_out);
    end
  endtask

  task automatic test_single_push();
    step(1'b1, 16'h1234, 16'hFEDC, 1'b0);
    tests++;
    if ({sample_valid_out, fill_level_out, left_sample_out, right_sample_out} !== {1'b1, 5'd1, 16'h1234, 16'hFEDC}) begin
      fails++;
      $display("FAIL single_push: got v=%b lvl=%0d L=%h R=%h, want v=1 lvl=1 L=1234 R=fedc",
               sample_valid_out, fill_level_out, left_sample_out, right_sample_out);
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0);
      tests++;
      if ({sample_valid_out, fill_level_out, left_sample_out, right_sample_out} !== {1'b1, 5'd1, 16'h1234, 16'hFEDC}) begin
        fails++;
        $display("FAIL single_hold cyc %0d: got v=%b lvl=%0d L=%h R=%h, want held 1234/fedc",
                 k, sample_valid_out, fill_level_out, left_sample_out, right_sample_out);
      end
    end
    step(1'b0, 16'h0, 16'h0, 1'b1);
    tests++;
    if (obs_vec() !== exp_vec() || sample_valid_out !== 1'b0 || fill_level_out !== 5'd0) begin
      fails++;
      $display("FAIL single_pop: got v=%b lvl=%0d, want v=0 lvl=0", sample_valid_out, fill_level_out);
    end
  endtask

  task automatic test_fill_drain();
    logic [15:0] lv, rv;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(i), 16'(-i), 1'b0);
    tests++;
    if (fill_level_out !== 5'd16 || overflow_out !== 1'b0 || obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL fill_level: got lvl=%0d ovf=%b, want lvl=16 ovf=0", fill_level_out, overflow_out);
    end
    for (int i = 0; i < DEPTH; i++) begin
      lv = 16'(i);
      rv = 16'(-i);
      tests++;
      if (sample_valid_out !== 1'b1 || {left_sample_out, right_sample_out} !== {lv, rv}) begin
        fails++;
        $display("FAIL drain_order idx %0d: got v=%b L=%h R=%h, want v=1 L=%h R=%h",
                 i, sample_valid_out, left_sample_out, right_sample_out, lv, rv);
      end
      step(1'b0, 16'h0, 16'h0, 1'b1);
    end
    tests++;
    if (sample_valid_out !== 1'b0 || fill_level_out !== 5'd0) begin
      fails++;
      $display("FAIL drain_end: got v=%b lvl=%0d, want v=0 lvl=0", sample_valid_out, fill_level_out);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(16'h4000 + i), 16'(16'h8000 + i), 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 16'(16'h7000 + k), 16'h7777, 1'b0);
    tests++;
    if (drop_count_out !== 16'd3 || overflow_out !== 1'b1 || fill_level_out !== 5'd16 || obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL overflow_drop: got drops=%0d ovf=%b lvl=%0d, want drops=3 ovf=1 lvl=16",
               drop_count_out, overflow_out, fill_level_out);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tests++;
      if (sample_valid_out !== 1'b1 || {left_sample_out, right_sample_out} !== {16'(16'h4000 + i), 16'(16'h8000 + i)}) begin
        fails++;
        $display("FAIL overflow_drain idx %0d: got v=%b L=%h R=%h, want original entry",
                 i, sample_valid_out, left_sample_out, right_sample_out);
      end
      step(1'b0, 16'h0, 16'h0, 1'b1);
    end
    tests++;
    if (sample_valid_out !== 1'b0 || overflow_out !== 1'b1 || drop_count_out !== 16'd3) begin
      fails++;
      $display("FAIL overflow_sticky: got v=%b ovf=%b drops=%0d, want v=0 ovf=1 drops=3",
               sample_valid_out, overflow_out, drop_count_out);
    end
  endtask

  task automatic test_full_push_pop();
    int drops_before;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(16'h0100 + i), 16'(16'h0200 + i), 1'b0);
    drops_before = m_drops;
    step(1'b1, 16'hAAAA, 16'h5555, 1'b1);
    tests++;
    if (fill_level_out !== 5'd16 || drop_count_out !== DROP_W'(drops_before) || obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL full_push_pop: got lvl=%0d drops=%0d, want lvl=16 drops=%0d",
               fill_level_out, drop_count_out, drops_before);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL full_pp_drain idx %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == DEPTH - 1) begin
        tests++;
        if ({left_sample_out, right_sample_out} !== 32'hAAAA5555) begin
          fails++;
          $display("FAIL full_pp_last: got L=%h R=%h, want aaaa/5555", left_sample_out, right_sample_out);
        end
      end
      step(1'b0, 16'h0, 16'h0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    int drops_before;
    drops_before = m_drops;
    step(1'b1, 16'hBEEF, 16'h0042, 1'b1);
    tests++;
    if ({sample_valid_out, fill_level_out, left_sample_out, right_sample_out} !== {1'b1, 5'd1, 16'hBEEF, 16'h0042}) begin
      fails++;
      $display("FAIL empty_push_ready: got v=%b lvl=%0d L=%h R=%h, want v=1 lvl=1 beef/0042",
               sample_valid_out, fill_level_out, left_sample_out, right_sample_out);
    end
    step(1'b0, 16'h0, 16'h0, 1'b1);
    tests++;
    if (sample_valid_out !== 1'b0 || fill_level_out !== 5'd0) begin
      fails++;
      $display("FAIL one_valid_cycle: got v=%b lvl=%0d, want v=0 lvl=0", sample_valid_out, fill_level_out);
    end
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 16'(16'h0300 + k), 16'(16'h0400 + k), 1'b1);
      tests++;
      if (obs_vec() !== exp_vec() || {left_sample_out, right_sample_out} !== {16'(16'h0300 + k), 16'(16'h0400 + k)}
          || drop_count_out !== DROP_W'(drops_before)) begin
        fails++;
        $display("FAIL back_to_back cyc %0d: got v=%b lvl=%0d L=%h R=%h drops=%0d", k,
                 sample_valid_out, fill_level_out, left_sample_out, right_sample_out, drop_count_out);
      end
    end
    step(1'b0, 16'h0, 16'h0, 1'b1);
    tests++;
    if (sample_valid_out !== 1'b0 || fill_level_out !== 5'd0) begin
      fails++;
      $display("FAIL b2b_end: got v=%b lvl=%0d, want v=0 lvl=0", sample_valid_out, fill_level_out);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 16'(16'h0500 + i), 16'(16'h0600 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 16'h0, 1'b1);
    tests++;
    if (fill_level_out !== 5'd7 || obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL pre_reset_level: got lvl=%0d, want 7", fill_level_out);
    end
    #2;
    reset_in = 1'b1;
    #1;
    tests++;
    if ({sample_valid_out, fill_level_out, overflow_out, drop_count_out} !== '0) begin
      fails++;
      $display("FAIL async_reset: got v=%b lvl=%0d ovf=%b drops=%0d before edge, want all zero",
               sample_valid_out, fill_level_out, overflow_out, drop_count_out);
    end
    mq.delete();
    m_drops = 0;
    m_ovf   = 1'b0;
    new_sample_in   = 1'b0;
    sample_ready_in = 1'b0;
    #1;
    reset_in = 1'b0;
    step(1'b1, 16'h1234, 16'hFEDC, 1'b0);
    tests++;
    if ({sample_valid_out, fill_level_out, left_sample_out, right_sample_out} !== {1'b1, 5'd1, 16'h1234, 16'hFEDC}) begin
      fails++;
      $display("FAIL post_reset_push: got v=%b lvl=%0d L=%h R=%h, want v=1 lvl=1 1234/fedc",
               sample_valid_out, fill_level_out, left_sample_out, right_sample_out);
    end
  endtask

  task automatic test_random();
    bit nw, rdy, stall;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      stall = ((c / 150) % 2) == 1;
      nw  = ($urandom_range(0, 99) < 45);
      rdy = stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      step(nw, 16'($urandom), 16'($urandom), rdy);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stereo_sample_fifo.md
Name: stereo_sample_fifo

Overview:
Buffers stereo microphone samples from the I2S receiver stage, which presents one 16-bit left and one 16-bit right sample with a 1-cycle new-sample pulse per 64-BCLK frame. Decouples that fixed-rate producer from downstream processing (filtering/FFT) through a valid/ready handshake. Detects and counts drops when downstream stalls too long.

Parameters:
DEPTH, 16, number of stereo entries; power of 2, at least 2
LEVEL_W, $clog2(DEPTH)+1, width of fill level output
DROP_W, 16, width of saturating drop counter

Ports:
clock_in  input  1  system clock, 100 MHz
reset_in  input  1  asynchronous, active-high reset
left_sample_in  input  16  signed left sample from receiver
right_sample_in  input  16  signed right sample from receiver
new_sample_in  input  1  1-cycle write strobe; samples valid this cycle
left_sample_out  output  16  signed left sample at FIFO head
right_sample_out  output  16  signed right sample at FIFO head
sample_valid_out  output  1  head entry valid
sample_ready_in  input  1  consumer accepts head when valid&&ready
fill_level_out  output  LEVEL_W  entries stored, 0..DEPTH
overflow_out  output  1  sticky; set on first dropped sample
drop_count_out  output  DROP_W  dropped samples, saturating

Behaviour:
- Single clock_in domain. reset_in is asynchronous and active-high. All state clears on assert: ptrs=0, fill_level_out=0, sample_valid_out=0, left/right_sample_out=0, overflow_out=0, drop_count_out=0.
- Entry is {left,right}, 32 bits, written atomically. The channels are never split.
- Push: new_sample_in=1 and (not full, or full with a pop in the same cycle) writes at wr_ptr, and wr_ptr increments.
- Pop: sample_valid_out && sample_ready_in at a rising edge consumes the head, and rd_ptr increments.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Empty: ptrs equal. Full: MSB differs and rest equal.
- Output is show-ahead and registered. The head data is presented with valid one cycle after it is written into an empty FIFO. Write-to-valid latency is 1 cycle, not combinational.
- While valid && !ready, left/right_sample_out and sample_valid_out hold stable.
- Back-to-back pops with ready held high deliver one entry per cycle until empty. Valid deasserts the cycle after the last entry pops.
- Simultaneous push and pop:
  - When empty: no pop occurs (valid is 0), and the push is stored.
  - When full: both happen, and the level stays at DEPTH.
  - Otherwise: level unchanged.
- fill_level_out: +1 on push only, -1 on pop only, 0 change on both. It is registered and matches the state after the edge.
- Drop: new_sample_in=1, full, and no pop that cycle. The new sample is discarded and FIFO contents are unchanged. overflow_out is set to 1 and stays set until reset. drop_count_out increments and saturates at 2^DROP_W-1.
- new_sample_in pulses arrive at most once per ~1536 clocks in normal use. The block nevertheless supports pushes on consecutive cycles.
- Reset asserted mid-operation discards all contents immediately (asynchronous). The first post-reset push behaves as a push into an empty FIFO.
- Data is passed unmodified. There is no sign extension or arithmetic.

Decomposition:
- Package audio_pkg:
  - SAMPLE_W=16
  - typedef struct packed {logic signed [15:0] left; logic signed [15:0] right;} stereo_sample_t
  - Shared by the receiver consumers and later DSP stages.
- Sub-module sample_ram: simple dual-port memory, DEPTH x 32. Synchronous write and synchronous read (BRAM/LUTRAM inferable). The FIFO control wraps it and handles read-ahead so that show-ahead still meets the 1-cycle latency.

Test Plan:
- Reset, then one push (L=16'h1234, R=16'hFEDC) with ready=0 -> next cycle: valid=1, outputs 1234/FEDC, level=1. Outputs hold for 10 cycles. Raise ready -> valid=0 the next cycle, level=0.
- 16 pushes (L=i, R=-i) with ready=0 -> level=16, overflow=0. Then drain with ready=1 -> 16 consecutive outputs in order 0..15 / 0..-15, then valid=0.
- Fill to 16, then 3 more pushes with ready=0 -> drop_count=3, overflow=1, level=16. Drain -> only the original 16 samples appear. overflow stays 1.
- Full FIFO, push and pop in the same cycle -> level stays 16, drop_count unchanged, and the pushed sample appears last on drain.
- Empty FIFO, push with ready=1 held -> the sample appears for exactly one valid cycle and level returns to 0. Then hold pushes every cycle for 20 cycles with ready=1 -> no drops, values in order.
- Reset asserted asynchronously mid-drain with level=7 -> valid=0, level=0, overflow=0, drop_count=0 before the next clock edge. A subsequent push behaves as in the first scenario.
